// File: rtl/calc_sequencer.sv
// calc_sequencer: single-clock controller between the keypad encoder and the
// calculator ALU. Collects operand A, an operator and operand B from one-cycle
// key events, launches one ALU operation with a start/done handshake, then
// shows the BCD result or an error on four display nibbles.
module calc_sequencer #(
  parameter int MAX_DIGITS = 2,
  parameter int TIMEOUT    = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [7:0]  key_code,
  output logic        alu_start,
  output logic [1:0]  alu_op,
  output logic [6:0]  opa,
  output logic [6:0]  opb,
  input  logic        alu_done,
  input  logic        alu_err,
  input  logic [15:0] res_bcd,
  output logic [15:0] disp_digits,
  output logic        busy,
  output logic        err
);

  // Timeout counter only needs to hold 0..TIMEOUT-1; EXEC is left on the last value.
  localparam int              TW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0]   TLAST = TW'(TIMEOUT - 1);
  localparam logic [1:0]      MAXD  = 2'(MAX_DIGITS);

  localparam logic [15:0] DISP_BLANK = 16'hFFFF;
  localparam logic [15:0] DISP_ERR   = 16'hFFFE;

  typedef enum logic [2:0] {A_ENTRY, B_ENTRY, EXEC, SHOW, ERROR} state_t;

  state_t        state, state_n;
  logic [6:0]    opa_n, opb_n;
  logic [1:0]    op_n;
  logic [15:0]   disp_n;
  logic [1:0]    cnt, cnt_n;
  logic [TW-1:0] tmo, tmo_n;
  logic          start_n;

  logic          is_digit, is_op, is_eq, is_clr, can_digit;
  logic [1:0]    key_op;
  logic [3:0]    digit;
  logic [6:0]    acc_src, acc_val;
  logic [15:0]   acc_disp;

  // Classify the incoming key; anything unrecognised leaves every flag low.
  always_comb begin
    is_digit = key_valid && (key_code <= 8'd9);
    digit    = key_code[3:0];
    is_eq    = key_valid && (key_code == 8'h48);
    is_clr   = key_valid && (key_code == 8'h18);
    is_op    = 1'b0;
    key_op   = 2'b00;
    if (key_valid) begin
      case (key_code)
        8'h82:   begin is_op = 1'b1; key_op = 2'b00; end
        8'h84:   begin is_op = 1'b1; key_op = 2'b01; end
        8'h88:   begin is_op = 1'b1; key_op = 2'b10; end
        8'h28:   begin is_op = 1'b1; key_op = 2'b11; end
        default: begin is_op = 1'b0; key_op = 2'b00; end
      endcase
    end
  end

  // Decimal accumulation for the operand being entered; the previous value is a
  // single digit whenever a second digit is accepted, so it doubles as the tens nibble.
  always_comb begin
    acc_src   = (state == B_ENTRY) ? opb : opa;
    acc_val   = acc_src * 7'd10 + {3'b000, digit};
    acc_disp  = (cnt == 2'd0) ? {12'hFFF, digit} : {8'hFF, acc_src[3:0], digit};
    can_digit = is_digit && (cnt < MAXD);
  end

  // Next-state and next-register logic; clear overrides every state and alu_done.
  always_comb begin
    state_n = state;
    opa_n   = opa;
    opb_n   = opb;
    op_n    = alu_op;
    disp_n  = disp_digits;
    cnt_n   = cnt;
    tmo_n   = tmo;
    start_n = 1'b0;
    if (is_clr) begin
      state_n = A_ENTRY;
      opa_n   = 7'd0;
      opb_n   = 7'd0;
      op_n    = 2'b00;
      disp_n  = DISP_BLANK;
      cnt_n   = 2'd0;
      tmo_n   = '0;
    end else begin
      case (state)
        A_ENTRY: begin
          if (can_digit) begin
            opa_n  = acc_val;
            cnt_n  = cnt + 2'd1;
            disp_n = acc_disp;
          end else if (is_op && (cnt != 2'd0)) begin
            op_n    = key_op;
            state_n = B_ENTRY;
            cnt_n   = 2'd0;
            disp_n  = DISP_BLANK;
          end
        end
        B_ENTRY: begin
          if (can_digit) begin
            opb_n  = acc_val;
            cnt_n  = cnt + 2'd1;
            disp_n = acc_disp;
          end else if (is_op) begin
            op_n = key_op;
          end else if (is_eq && (cnt != 2'd0)) begin
            state_n = EXEC;
            tmo_n   = '0;
            start_n = 1'b1;
          end
        end
        EXEC: begin
          tmo_n = tmo + TW'(1);
          if (alu_done) begin
            if (alu_err) begin
              state_n = ERROR;
              disp_n  = DISP_ERR;
            end else begin
              state_n = SHOW;
              disp_n  = res_bcd;
            end
          end else if (tmo == TLAST) begin
            state_n = ERROR;
            disp_n  = DISP_ERR;
          end
        end
        SHOW, ERROR: begin
          if (is_digit) begin
            state_n = A_ENTRY;
            opa_n   = {3'b000, digit};
            opb_n   = 7'd0;
            cnt_n   = 2'd1;
            disp_n  = {12'hFFF, digit};
          end
        end
        default: state_n = A_ENTRY;
      endcase
    end
  end

  // State and datapath registers with asynchronous reset to the idle entry state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= A_ENTRY;
      opa         <= 7'd0;
      opb         <= 7'd0;
      alu_op      <= 2'b00;
      disp_digits <= DISP_BLANK;
      cnt         <= 2'd0;
      tmo         <= '0;
      alu_start   <= 1'b0;
    end else begin
      state       <= state_n;
      opa         <= opa_n;
      opb         <= opb_n;
      alu_op      <= op_n;
      disp_digits <= disp_n;
      cnt         <= cnt_n;
      tmo         <= tmo_n;
      alu_start   <= start_n;
    end
  end

  assign busy = (state == EXEC);
  assign err  = (state == ERROR);

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Control FSM between the keypad encoder and the arithmetic datapath of the two-operand calculator.
- Turns one-cycle key events into operand A, operator and operand B, then launches one ALU operation with a start/done handshake.
- Latches the result or error and drives the four BCD display nibbles.
- Replaces the pressed-edge-clocked FSM with a single-clock synchronous controller.

Parameters:
- MAX_DIGITS, 2, maximum decimal digits accepted per operand (1..2).
- TIMEOUT, 1023, clk cycles to wait for alu_done before flagging an error (≥1).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- key_valid  input  1  one-cycle pulse: key_code is valid.
- key_code  input  8  encoder code: 0..9 digit; 8'h82 add; 8'h84 sub; 8'h88 mul; 8'h28 div; 8'h48 equal; 8'h18 clear; anything else is invalid.
- alu_start  output  1  one-cycle launch pulse.
- alu_op  output  2  00 add, 01 sub, 10 mul, 11 div; stable from start until done.
- opa  output  7  operand A, binary 0..99.
- opb  output  7  operand B, binary 0..99.
- alu_done  input  1  one-cycle completion pulse.
- alu_err  input  1  qualified by alu_done: negative result, or divide by zero.
- res_bcd  input  16  BCD result from the converter, sampled on alu_done.
- disp_digits  output  16  {d4,d3,d2,d1} BCD nibbles; 4'hF = blank, 4'hE = "E".
- busy  output  1  high in EXEC.
- err  output  1  high in ERROR.

Behaviour:
- Reset (async): state=A_ENTRY; opa=opb=0; alu_op=00; alu_start=0; disp_digits=16'hFFFF; busy=0; err=0; digit counters=0; timeout counter=0.
- Key events are sampled on the clk edge where key_valid=1. State/register updates are visible the next cycle.
- Clear at any state: next cycle state=A_ENTRY, all outputs return to reset values. This takes priority over everything, including a simultaneous alu_done.
- Invalid codes are ignored in every state.
- A_ENTRY:
  - Digit with count<MAX_DIGITS: opa←opa*10+digit, count++. Display shows entered digits right-aligned in d2,d1; unused nibbles are F.
  - Digits beyond MAX_DIGITS are ignored.
  - Op key with count≥1: latch alu_op, go to B_ENTRY, display=FFFF.
  - Op key with count=0, or equal: ignored.
- B_ENTRY:
  - Digits are handled as in A_ENTRY, into opb.
  - Op key: replaces alu_op.
  - Equal with count≥1: go to EXEC.
  - Equal with count=0: ignored.
- EXEC:
  - alu_start=1 for exactly the first cycle in EXEC; busy=1 throughout.
  - All keys except clear are ignored.
  - On alu_done with alu_err=0: disp_digits←res_bcd, go to SHOW.
  - On alu_done with alu_err=1: go to ERROR.
  - Timeout counter starts at 0 on entry and counts each cycle. If it reaches TIMEOUT without alu_done, go to ERROR.
  - alu_done outside EXEC is ignored.
- SHOW: the result is held.
  - Digit key: opa←digit, count=1, opb←0, display=FFF&digit, go to A_ENTRY.
  - Op and equal keys: ignored.
- ERROR: display=FFFE, err=1.
  - Digit key: behaves as in SHOW and clears err.
- opa/opb never exceed 99. The datapath owns arithmetic widths; a product ≤9801 fits in 14 bits.
- Reset asserted mid-EXEC aborts the operation; a later alu_done is ignored.

Test Plan:
- Keys 1,2,add,3,4,equal; ALU returns done with res_bcd=16'h0046 three cycles after start -> opa=12, opb=34, alu_op=00, a single alu_start pulse, busy high for 3 cycles, disp_digits=16'h0046.
- Keys 9,9,9,mul,9,9,equal -> third 9 ignored, opa=99, opb=99, alu_op=10; res_bcd=16'h9801 gives disp 9801.
- Keys 5,div,0,equal; ALU returns done with alu_err=1 -> state ERROR, disp=16'hFFFE, err=1. Then key 7 -> err=0, disp=16'hFFF7, opa=7.
- Keys 3,sub,2,equal with no alu_done -> ERROR exactly TIMEOUT cycles after entering EXEC (set TIMEOUT=8). Verify busy drops.
- Keys add, equal at reset, then 4,sub,mul,6,equal -> first two keys ignored, alu_op=10 at start, opa=4, opb=6.
- During EXEC inject clear in the same cycle as alu_done -> next cycle state A_ENTRY, disp=FFFF, no latch of res_bcd. Async rst mid-entry clears all outputs immediately.
